// File: rtl/uart_phy.sv
// ISP debug UART front end: 4x oversampled 8N1 receiver and a 9-frame line transmitter.
// Define UART_PHY_FRAME_ERR_EN to add the o_frame_err pulse output.
module uart_phy #(
    parameter int UART_RX_CLK_DIV = 108,
    parameter int UART_TX_CLK_DIV = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rx,
    output logic        o_ready,
    output logic [7:0]  o_data,
`ifdef UART_PHY_FRAME_ERR_EN
    output logic        o_frame_err,
`endif
    output logic        o_tx,
    input  logic        i_start,
    input  logic [63:0] i_data,
    output logic        o_busy,
    output logic        o_fin
);
    // state    | meaning
    // RX_IDLE  | line idle, looking for a tick that reads 0
    // RX_START | qualifying the start bit on the next two ticks
    // RX_DATA  | sampling 8 data bits, LSB first, every 4th tick
    // RX_STOP  | sampling the stop bit 4 ticks after bit 7
    // RX_WAIT  | framing error, waiting for the line to read 1
    // TX_IDLE  | ready to accept i_start
    // TX_SEND  | shifting out 9 frames (8 chars + newline)

    localparam int RXW = (UART_RX_CLK_DIV > 1) ? $clog2(UART_RX_CLK_DIV) : 1;
    localparam int TXW = (UART_TX_CLK_DIV > 1) ? $clog2(UART_TX_CLK_DIV) : 1;

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

    logic            rx_meta, rx_s;
    logic [RXW-1:0]  rx_div_cnt;
    logic            rx_tick;
    rx_state_t       rx_state;
    logic [1:0]      rx_phase;
    logic [2:0]      rx_bit;
    logic [7:0]      rx_shift;

    tx_state_t       tx_state;
    logic [71:0]     tx_chars;
    logic [89:0]     tx_line;
    logic [89:0]     tx_shift;
    logic [6:0]      tx_bits_left;
    logic [TXW-1:0]  tx_div_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    assign rx_tick = (rx_div_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst || rx_tick) rx_div_cnt <= RXW'(UART_RX_CLK_DIV - 1);
        else                rx_div_cnt <= rx_div_cnt - 1'b1;
    end

    // A start must read 0 on both following ticks; the second lands mid-bit and
    // rejects low pulses shorter than half a bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_phase <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            o_ready  <= 1'b0;
            o_data   <= 8'h00;
`ifdef UART_PHY_FRAME_ERR_EN
            o_frame_err <= 1'b0;
`endif
        end else begin
            o_ready <= 1'b0;
`ifdef UART_PHY_FRAME_ERR_EN
            o_frame_err <= 1'b0;
`endif
            if (rx_tick) begin
                case (rx_state)
                    RX_IDLE: begin
                        if (!rx_s) begin
                            rx_state <= RX_START;
                            rx_phase <= 2'd1;
                        end
                    end
                    RX_START: begin
                        if (rx_s) begin
                            rx_state <= RX_IDLE;
                        end else if (rx_phase == 2'd0) begin
                            rx_state <= RX_DATA;
                            rx_phase <= 2'd3;
                            rx_bit   <= 3'd7;
                        end else begin
                            rx_phase <= rx_phase - 2'd1;
                        end
                    end
                    RX_DATA: begin
                        if (rx_phase == 2'd0) begin
                            rx_shift <= {rx_s, rx_shift[7:1]};
                            rx_phase <= 2'd3;
                            if (rx_bit == 3'd0) rx_state <= RX_STOP;
                            else                rx_bit   <= rx_bit - 3'd1;
                        end else begin
                            rx_phase <= rx_phase - 2'd1;
                        end
                    end
                    RX_STOP: begin
                        if (rx_phase != 2'd0) begin
                            rx_phase <= rx_phase - 2'd1;
                        end else if (rx_s) begin
                            o_data   <= rx_shift;
                            o_ready  <= 1'b1;
                            rx_state <= RX_IDLE;
                        end else begin
`ifdef UART_PHY_FRAME_ERR_EN
                            o_frame_err <= 1'b1;
`endif
                            rx_state <= RX_WAIT;
                        end
                    end
                    RX_WAIT: begin
                        if (rx_s) rx_state <= RX_IDLE;
                    end
                    default: rx_state <= RX_IDLE;
                endcase
            end
        end
    end

    // Whole line laid out as 90 serial bits, first bit in position 0.
    assign tx_chars = {i_data, 8'h0A};

    always_comb begin
        tx_line = '0;
        for (int k = 0; k < 9; k++) begin
            tx_line[10*k +: 10] = {1'b1, tx_chars[71-8*k -: 8], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state     <= TX_IDLE;
            tx_shift     <= '0;
            tx_bits_left <= '0;
            tx_div_cnt   <= '0;
            o_tx         <= 1'b1;
            o_busy       <= 1'b0;
            o_fin        <= 1'b0;
        end else begin
            o_fin <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (i_start) begin
                        tx_state     <= TX_SEND;
                        o_busy       <= 1'b1;
                        o_tx         <= tx_line[0];
                        tx_shift     <= {1'b0, tx_line[89:1]};
                        tx_bits_left <= 7'd89;
                        tx_div_cnt   <= TXW'(UART_TX_CLK_DIV - 1);
                    end
                end
                TX_SEND: begin
                    if (tx_div_cnt != '0) begin
                        tx_div_cnt <= tx_div_cnt - 1'b1;
                    end else if (tx_bits_left == 7'd0) begin
                        tx_state <= TX_IDLE;
                        o_busy   <= 1'b0;
                        o_fin    <= 1'b1;
                        o_tx     <= 1'b1;
                    end else begin
                        o_tx         <= tx_shift[0];
                        tx_shift     <= {1'b0, tx_shift[89:1]};
                        tx_bits_left <= tx_bits_left - 7'd1;
                        tx_div_cnt   <= TXW'(UART_TX_CLK_DIV - 1);
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_phy.sv
// Self-checking bench for uart_phy: directed and random RX frames, TX lines decoded off the pin.
module tb_uart_phy;
    localparam int RX_DIV = 4;
    localparam int TX_DIV = 16;
    localparam int BIT    = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_rx = 1'b1;
    logic        i_start = 1'b0;
    logic [63:0] i_data = '0;
    logic        o_ready, o_tx, o_busy, o_fin;
    logic [7:0]  o_data;
`ifdef UART_PHY_FRAME_ERR_EN
    logic        o_frame_err;
`endif

    uart_phy #(.UART_RX_CLK_DIV(RX_DIV), .UART_TX_CLK_DIV(TX_DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_rx    (i_rx),
        .o_ready (o_ready),
        .o_data  (o_data),
`ifdef UART_PHY_FRAME_ERR_EN
        .o_frame_err (o_frame_err),
`endif
        .o_tx    (o_tx),
        .i_start (i_start),
        .i_data  (i_data),
        .o_busy  (o_busy),
        .o_fin   (o_fin)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ready_cnt = 0;
    int fin_cnt   = 0;
    int ferr_cnt  = 0;
    logic [7:0] dec_q[$];
    logic [7:0] exp_q[$];
    int dec_bad_stop = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_ready === 1'b1) ready_cnt++;
        if (o_fin === 1'b1) fin_cnt++;
`ifdef UART_PHY_FRAME_ERR_EN
        if (o_frame_err === 1'b1) ferr_cnt++;
`endif
    end

    // Pin-level 8N1 decoder: finds the start edge, then samples each bit mid-cell.
    initial begin : tx_decoder
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (o_tx === 1'b0) begin
                repeat (BIT/2) @(negedge clk);
                if (o_tx === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (BIT) @(negedge clk);
                        b[i] = o_tx;
                    end
                    repeat (BIT) @(negedge clk);
                    if (o_tx !== 1'b1) dec_bad_stop++;
                    dec_q.push_back(b);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop);
        i_rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            i_rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        i_rx = stop;
        repeat (BIT) @(negedge clk);
        i_rx = 1'b1;
    endtask

    task automatic push_line(input logic [63:0] d);
        for (int k = 7; k >= 0; k--) exp_q.push_back(d[8*k +: 8]);
        exp_q.push_back(8'h0A);
    endtask

    task automatic check_line(input string tag);
        chk({tag, "_len"}, 64'(dec_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < dec_q.size()) chk($sformatf("%s_ch%0d", tag, i), {56'd0, dec_q[i]}, {56'd0, exp_q[i]});
        end
        chk({tag, "_stop"}, 64'(dec_bad_stop), 64'd0);
        dec_q.delete();
        exp_q.delete();
    endtask

    task automatic start_line(input logic [63:0] d);
        i_data  = d;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_fin(input string tag, input int t_busy);
        int guard;
        guard = 0;
        while (o_fin !== 1'b1 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_fin_seen"}, {63'd0, o_fin}, 64'd1);
        chk({tag, "_fin_time"}, 64'(cyc - t_busy), 64'(9 * 10 * TX_DIV));
        chk({tag, "_busy_at_fin"}, {63'd0, o_busy}, 64'd0);
    endtask

    initial begin
        int r0, f0, t_busy;
        logic [7:0] rb;
        logic [63:0] rl;

        repeat (3) @(negedge clk);
        chk("rst_tx", {63'd0, o_tx}, 64'd1);
        chk("rst_ready", {63'd0, o_ready}, 64'd0);
        chk("rst_data", {56'd0, o_data}, 64'h00);
        chk("rst_busy", {63'd0, o_busy}, 64'd0);
        chk("rst_fin", {63'd0, o_fin}, 64'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        r0 = ready_cnt;
        rx_send(8'h72, 1'b1);
        chk("rx72_ready", 64'(ready_cnt - r0), 64'd1);
        chk("rx72_data", {56'd0, o_data}, 64'h72);
        r0 = ready_cnt;
        rx_send(8'h0D, 1'b1);
        chk("rx0d_ready", 64'(ready_cnt - r0), 64'd1);
        chk("rx0d_data", {56'd0, o_data}, 64'h0D);

        r0 = ready_cnt;
        f0 = ferr_cnt;
        rx_send(8'h55, 1'b0);
        repeat (2*BIT) @(negedge clk);
        chk("rxerr_ready", 64'(ready_cnt - r0), 64'd0);
        chk("rxerr_data", {56'd0, o_data}, 64'h0D);
`ifdef UART_PHY_FRAME_ERR_EN
        chk("rxerr_flag", 64'(ferr_cnt - f0), 64'd1);
`endif
        r0 = ready_cnt;
        rx_send(8'hA5, 1'b1);
        chk("rxa5_ready", 64'(ready_cnt - r0), 64'd1);
        chk("rxa5_data", {56'd0, o_data}, 64'hA5);

        r0 = ready_cnt;
        i_rx = 1'b0;
        repeat (8) @(negedge clk);
        i_rx = 1'b1;
        repeat (4*BIT) @(negedge clk);
        chk("glitch_ready", 64'(ready_cnt - r0), 64'd0);

        for (int n = 0; n < 4; n++) begin
            rb = 8'($urandom);
            r0 = ready_cnt;
            rx_send(rb, 1'b1);
            chk($sformatf("rxrand%0d_ready", n), 64'(ready_cnt - r0), 64'd1);
            chk($sformatf("rxrand%0d_data", n), {56'd0, o_data}, {56'd0, rb});
        end
        repeat (2*BIT) @(negedge clk);

        push_line("rst done");
        start_line("rst done");
        chk("tx1_busy", {63'd0, o_busy}, 64'd1);
        t_busy = cyc;
        repeat (99) @(negedge clk);
        start_line("invalid ");
        chk("tx1_busy_held", {63'd0, o_busy}, 64'd1);
        wait_fin("tx1", t_busy);
        check_line("tx1");

        rl = {$urandom, $urandom};
        @(negedge clk);
        push_line(rl);
        start_line(rl);
        chk("tx2_busy", {63'd0, o_busy}, 64'd1);
        t_busy = cyc;
        wait_fin("tx2", t_busy);
        check_line("tx2");
        repeat (4) @(negedge clk);
        chk("fin_count", 64'(fin_cnt), 64'd2);

        f0 = fin_cnt;
        r0 = ready_cnt;
        start_line({$urandom, $urandom});
        repeat (200) @(negedge clk);
        i_rx = 1'b0;
        repeat (3*BIT) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        i_rx = 1'b1;
        chk("abort_tx", {63'd0, o_tx}, 64'd1);
        chk("abort_busy", {63'd0, o_busy}, 64'd0);
        repeat (20*BIT) @(negedge clk);
        chk("abort_fin", 64'(fin_cnt - f0), 64'd0);
        chk("abort_ready", 64'(ready_cnt - r0), 64'd0);
        chk("abort_data", {56'd0, o_data}, 64'h00);
        dec_q.delete();
        dec_bad_stop = 0;

        r0 = ready_cnt;
        rx_send(8'h3C, 1'b1);
        chk("post_rst_ready", 64'(ready_cnt - r0), 64'd1);
        chk("post_rst_data", {56'd0, o_data}, 64'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
